// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with first-word-fall-through receive FIFO
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic                  r_en,
    input  logic                  ovr_clr,
    output logic [7:0]            r_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rxd_int,
    output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  overrun
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]    HALF_BIT = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]    FULL_BIT = CNT_W'(BAUD_DIV - 1);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                  rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  push_req, ferr_d, perr_d;
    logic                  rxd_int_q, frame_err_q, perr_q, overrun_q, overrun_d;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full, pop, push_ok, ovr_event, timer_done, after_data_par;

    // Edge detect uses rxd_prev_q so a line stuck low never retriggers a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    assign timer_done = (cnt_q == '0);
`ifdef UART_RX_PARITY_EN
    assign after_data_par = 1'b1;
`else
    assign after_data_par = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        push_req  = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (!timer_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxd_s2_q) begin
                    state_d   = DATA;
                    cnt_d     = FULL_BIT;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!timer_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxd_s2_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_idx_q == 3'd7) begin
                        state_d = after_data_par ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!timer_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_bit_d = rxd_s2_q;
                    cnt_d     = FULL_BIT;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (!timer_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    if (!rxd_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (after_data_par && (^{shift_q, par_bit_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
        end
    end

    // A pop frees the slot the simultaneous push needs, so full+pop never overruns.
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = r_en && !empty;
    assign push_ok   = push_req && (!full || pop);
    assign ovr_event = push_req && full && !pop;
    assign overrun_d = ovr_event ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rxd_int_q   <= 1'b0;
            frame_err_q <= 1'b0;
            perr_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            count_q     <= count_d;
            rxd_int_q   <= push_ok;
            frame_err_q <= ferr_d;
            perr_q      <= perr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign r_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign rxd_int   = rxd_int_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
